// File: rtl/mc_reg_write_arbiter.sv
// Round-robin write arbiter for a shared register bank of slow MC flip-flop cells.
// Each grant produces one single-cycle write strobe, followed by SETTLE idle cycles.
module mc_reg_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*WIDTH-1:0]    i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    output logic                     o_reg_we,
    output logic [WIDTH-1:0]         o_reg_d,
    output logic [$clog2(NREQ)-1:0]  o_grant_id,
    output logic                     o_busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   r_ptr;
    logic            r_reg_we;
    logic [WIDTH-1:0] r_reg_d;
    logic [PW-1:0]   r_grant;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic            w_accept;
    logic [WIDTH-1:0] w_win_data;
    logic [NREQ-1:0] w_req_ready;

    // Explicit modulo-NREQ wrap, so non-power-of-two NREQ never yields an out-of-range index.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return sum[PW-1:0];
    endfunction

    // Scan from the farthest offset down so the offset closest to r_ptr is written last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (i_req_valid[rr_index(r_ptr, k - 1)]) begin
                w_found  = 1'b1;
                w_winner = rr_index(r_ptr, k - 1);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) w_win_data = i_req_data[i*WIDTH +: WIDTH];
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    always_comb begin
        w_req_ready = '0;
        if (i_arst_n && w_accept) w_req_ready[w_winner] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (SETTLE == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = CW'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A reset during WRITE/SETTLE discards the in-flight grant; the pointer restarts at 0.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_reg_we <= 1'b0;
            r_reg_d  <= '0;
            r_grant  <= '0;
            r_ptr    <= '0;
        end else begin
            r_reg_we <= w_accept;
            if (w_accept) begin
                r_reg_d <= w_win_data;
                r_grant <= w_winner;
                r_ptr   <= rr_index(w_winner, 1);
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_reg_we    = r_reg_we;
    assign o_reg_d     = r_reg_d;
    assign o_grant_id  = r_grant;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mc_reg_write_arbiter.sv
// Directed bench for mc_reg_write_arbiter: main build (4 req, SETTLE=2),
// a SETTLE=0 build and an NREQ=3 build share one clock and reset.
module tb_mc_reg_write_arbiter;

    logic clk;
    logic rst_n;

    // Main instance: NREQ=4, WIDTH=8, SETTLE=2
    logic [3:0]  m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_ready;
    logic        m_we;
    logic [7:0]  m_d;
    logic [1:0]  m_gid;
    logic        m_busy;

    // SETTLE=0 instance
    logic [3:0]  z_valid;
    logic [31:0] z_data;
    logic [3:0]  z_ready;
    logic        z_we;
    logic [7:0]  z_d;
    logic [1:0]  z_gid;
    logic        z_busy;

    // NREQ=3 instance, SETTLE=1
    logic [2:0]  t_valid;
    logic [23:0] t_data;
    logic [2:0]  t_ready;
    logic        t_we;
    logic [7:0]  t_d;
    logic [1:0]  t_gid;
    logic        t_busy;

    int n_checks;
    int n_fail;

    mc_reg_write_arbiter #(.NREQ(4), .WIDTH(8), .SETTLE(2)) u_main (
        .i_clk(clk), .i_arst_n(rst_n),
        .i_req_valid(m_valid), .i_req_data(m_data), .o_req_ready(m_ready),
        .o_reg_we(m_we), .o_reg_d(m_d), .o_grant_id(m_gid), .o_busy(m_busy)
    );

    mc_reg_write_arbiter #(.NREQ(4), .WIDTH(8), .SETTLE(0)) u_s0 (
        .i_clk(clk), .i_arst_n(rst_n),
        .i_req_valid(z_valid), .i_req_data(z_data), .o_req_ready(z_ready),
        .o_reg_we(z_we), .o_reg_d(z_d), .o_grant_id(z_gid), .o_busy(z_busy)
    );

    mc_reg_write_arbiter #(.NREQ(3), .WIDTH(8), .SETTLE(1)) u_n3 (
        .i_clk(clk), .i_arst_n(rst_n),
        .i_req_valid(t_valid), .i_req_data(t_data), .o_req_ready(t_ready),
        .o_reg_we(t_we), .o_reg_d(t_d), .o_grant_id(t_gid), .o_busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_valid = 4'hF; m_data = 32'h0403_0201;
        z_valid = 4'hF; z_data = 32'h0;
        t_valid = 3'h7; t_data = 24'h0;
        #12;
        n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", m_ready); end
        n_checks++; if (m_we !== 1'b0)       begin n_fail++; $display("FAIL reset_we: got %b expected 0", m_we); end
        n_checks++; if (m_d !== 8'h00)       begin n_fail++; $display("FAIL reset_d: got %h expected 00", m_d); end
        n_checks++; if (m_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
        n_checks++; if (m_gid !== 2'd0)      begin n_fail++; $display("FAIL reset_gid: got %0d expected 0", m_gid); end
        n_checks++; if (z_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_s0: got %b expected 0000", z_ready); end
        n_checks++; if (t_ready !== 3'b000)  begin n_fail++; $display("FAIL reset_ready_n3: got %b expected 000", t_ready); end
        @(posedge clk);
        #1;
        m_valid = '0; z_valid = '0; t_valid = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_single_write();
        m_valid = 4'b0100;
        m_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        n_checks++; if (m_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", m_ready); end
        n_checks++; if (m_busy !== 1'b0)     begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", m_busy); end
        tick();
        n_checks++; if (m_we !== 1'b1)   begin n_fail++; $display("FAIL single_we: got %b expected 1", m_we); end
        n_checks++; if (m_d !== 8'hA5)   begin n_fail++; $display("FAIL single_d: got %h expected a5", m_d); end
        n_checks++; if (m_gid !== 2'd2)  begin n_fail++; $display("FAIL single_gid: got %0d expected 2", m_gid); end
        n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_w: got %b expected 1", m_busy); end
        // Input changes during WRITE/SETTLE must not leak through.
        m_valid = 4'b1111;
        m_data  = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_w: got %b expected 0000", m_ready); end
        tick();
        n_checks++; if (m_we !== 1'b0)   begin n_fail++; $display("FAIL single_we_drop: got %b expected 0", m_we); end
        n_checks++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_s1: got %b expected 1", m_busy); end
        n_checks++; if (m_d !== 8'hA5)   begin n_fail++; $display("FAIL single_d_s1: got %h expected a5", m_d); end
        tick();
        n_checks++; if (m_busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy_s0: got %b expected 1", m_busy); end
        n_checks++; if (m_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_s0: got %b expected 0000", m_ready); end
        m_valid = 4'b0000;
        tick();
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", m_busy); end
        tick();
        n_checks++; if (m_gid !== 2'd2 || m_d !== 8'hA5 || m_we !== 1'b0)
            begin n_fail++; $display("FAIL single_hold: got gid=%0d d=%h we=%b expected gid=2 d=a5 we=0", m_gid, m_d, m_we); end
    endtask

    task automatic test_wrap_skip();
        // PTR is 3 here: an all-valid vector must favour requester 3.
        m_valid = 4'b1111;
        m_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        #1;
        n_checks++; if (m_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ptr3: got %b expected 1000", m_ready); end
        m_valid = 4'b1010;
        #1;
        n_checks++; if (m_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3: got %b expected 1000", m_ready); end
        tick();
        n_checks++; if (m_gid !== 2'd3 || m_d !== 8'h33 || m_we !== 1'b1)
            begin n_fail++; $display("FAIL wrap_grant3: got gid=%0d d=%h we=%b expected gid=3 d=33 we=1", m_gid, m_d, m_we); end
        m_valid = 4'b0010;
        tick(); tick(); tick();
        n_checks++; if (m_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready1: got %b expected 0010", m_ready); end
        tick();
        n_checks++; if (m_gid !== 2'd1 || m_d !== 8'h11 || m_we !== 1'b1)
            begin n_fail++; $display("FAIL wrap_grant1: got gid=%0d d=%h we=%b expected gid=1 d=11 we=1", m_gid, m_d, m_we); end
        m_valid = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_settle();
        // PTR is 2 here.
        m_valid = 4'b0100;
        m_data  = {8'h00, 8'h5A, 8'h00, 8'h00};
        #1;
        n_checks++; if (m_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0100", m_ready); end
        tick();
        n_checks++; if (m_we !== 1'b1 || m_d !== 8'h5A)
            begin n_fail++; $display("FAIL rst_mid_we: got we=%b d=%h expected we=1 d=5a", m_we, m_d); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", m_busy); end
        n_checks++; if (m_d !== 8'h00)   begin n_fail++; $display("FAIL rst_mid_d: got %h expected 00", m_d); end
        n_checks++; if (m_gid !== 2'd0 || m_we !== 1'b0 || m_ready !== 4'b0000)
            begin n_fail++; $display("FAIL rst_mid_outs: got gid=%0d we=%b rdy=%b expected gid=0 we=0 rdy=0000", m_gid, m_we, m_ready); end
        m_valid = 4'b0000;
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (m_ready !== 4'b0000 || m_busy !== 1'b0)
            begin n_fail++; $display("FAIL rst_rel: got rdy=%b busy=%b expected rdy=0000 busy=0", m_ready, m_busy); end
        tick();
        n_checks++; if (m_we !== 1'b0 || m_gid !== 2'd0)
            begin n_fail++; $display("FAIL rst_no_regrant: got we=%b gid=%0d expected we=0 gid=0", m_we, m_gid); end
        // Pointer restarted at 0: among {1,2}, requester 1 wins.
        m_valid = 4'b0110;
        m_data  = {8'h00, 8'h22, 8'h11, 8'h00};
        #1;
        n_checks++; if (m_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_ptr0: got %b expected 0010", m_ready); end
        tick();
        n_checks++; if (m_gid !== 2'd1 || m_d !== 8'h11)
            begin n_fail++; $display("FAIL rst_first_grant: got gid=%0d d=%h expected gid=1 d=11", m_gid, m_d); end
        m_valid = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int         exp_id;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        m_valid = 4'b1111;
        m_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        n_checks++; if (m_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_ready0: got %b expected 0001", m_ready); end
        for (int g = 0; g < 5; g++) begin
            exp_id  = g % 4;
            exp_rdy = 4'b0001 << ((exp_id + 1) % 4);
            tick();
            n_checks++; if (m_we !== 1'b1 || m_gid !== 2'(exp_id) || m_d !== 8'(8'h10 + exp_id))
                begin n_fail++; $display("FAIL rr_grant%0d: got we=%b gid=%0d d=%h expected we=1 gid=%0d d=%h", g, m_we, m_gid, m_d, exp_id, 8'(8'h10 + exp_id)); end
            tick();
            n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL rr_gap1_%0d: got we=%b expected 0", g, m_we); end
            tick();
            n_checks++; if (m_we !== 1'b0 || m_busy !== 1'b1)
                begin n_fail++; $display("FAIL rr_gap2_%0d: got we=%b busy=%b expected we=0 busy=1", g, m_we, m_busy); end
            tick();
            n_checks++; if (m_we !== 1'b0 || m_ready !== exp_rdy)
                begin n_fail++; $display("FAIL rr_idle%0d: got we=%b rdy=%b expected we=0 rdy=%b", g, m_we, m_ready, exp_rdy); end
        end
        m_valid = 4'b0000;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_settle_zero();
        logic [3:0] exp_rdy;
        int         exp_id;
        z_valid = 4'b0011;
        z_data  = {8'h00, 8'h00, 8'h21, 8'h20};
        #1;
        n_checks++; if (z_ready !== 4'b0001) begin n_fail++; $display("FAIL s0_ready0: got %b expected 0001", z_ready); end
        for (int g = 0; g < 4; g++) begin
            exp_id  = g % 2;
            exp_rdy = 4'b0001 << (1 - exp_id);
            tick();
            n_checks++; if (z_we !== 1'b1 || z_busy !== 1'b1 || z_gid !== 2'(exp_id) || z_d !== 8'(8'h20 + exp_id))
                begin n_fail++; $display("FAIL s0_write%0d: got we=%b busy=%b gid=%0d d=%h expected we=1 busy=1 gid=%0d", g, z_we, z_busy, z_gid, z_d, exp_id); end
            tick();
            n_checks++; if (z_we !== 1'b0 || z_busy !== 1'b0 || z_ready !== exp_rdy)
                begin n_fail++; $display("FAIL s0_idle%0d: got we=%b busy=%b rdy=%b expected we=0 busy=0 rdy=%b", g, z_we, z_busy, z_ready, exp_rdy); end
        end
        z_valid = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_nreq3_wrap();
        logic [2:0] exp_rdy;
        int         exp_id;
        t_valid = 3'b111;
        t_data  = {8'h32, 8'h31, 8'h30};
        #1;
        n_checks++; if (t_ready !== 3'b001) begin n_fail++; $display("FAIL n3_ready0: got %b expected 001", t_ready); end
        for (int g = 0; g < 4; g++) begin
            exp_id  = g % 3;
            exp_rdy = 3'b001 << ((exp_id + 1) % 3);
            tick();
            n_checks++; if (t_we !== 1'b1 || t_gid !== 2'(exp_id) || t_d !== 8'(8'h30 + exp_id))
                begin n_fail++; $display("FAIL n3_grant%0d: got we=%b gid=%0d d=%h expected we=1 gid=%0d", g, t_we, t_gid, t_d, exp_id); end
            tick();
            n_checks++; if (t_we !== 1'b0 || t_busy !== 1'b1)
                begin n_fail++; $display("FAIL n3_settle%0d: got we=%b busy=%b expected we=0 busy=1", g, t_we, t_busy); end
            tick();
            n_checks++; if (t_busy !== 1'b0 || t_ready !== exp_rdy)
                begin n_fail++; $display("FAIL n3_idle%0d: got busy=%b rdy=%b expected busy=0 rdy=%b", g, t_busy, t_ready, exp_rdy); end
        end
        t_valid = 3'b000;
        tick(); tick(); tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_write();
        test_wrap_skip();
        test_reset_mid_settle();
        test_round_robin();
        test_settle_zero();
        test_nreq3_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_reg_write_arbiter.md
# mc_reg_write_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit register bank built from the MC flip-flop cells. It accepts write requests from NREQ requesters over a valid/ready handshake and issues one single-cycle write strobe per grant. It then holds off further writes for SETTLE cycles so each slow redstone cell completes capture and output propagation before its D input changes again. The block sits between requester logic and the register bank's CLK-enable/D inputs.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- WIDTH, 8: register data width; must be 1 or more.
- SETTLE, 2: idle cycles inserted after each write strobe; legal range 0..15.
- CLK  in  1  clock; all state updates on rising edge.
- ARST  in  1  reset; asynchronous, active-low (0 = reset asserted).
- REQ_VALID  in  NREQ  per-requester write request.
- REQ_DATA  in  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_READY  out  NREQ  one-hot acceptance. Combinational from state, pointer and REQ_VALID.
- REG_WE  out  1  registered write strobe to the register bank.
- REG_D  out  WIDTH  registered write data to the register bank.
- GRANT_ID  out  clog2(NREQ)  index of the most recently accepted requester.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- The FSM has three states:
  - IDLE: accepts a request.
  - WRITE: drives REG_WE for exactly one cycle.
  - SETTLE: counts down SETTLE cycles.
- Round-robin pointer PTR, clog2(NREQ) bits:
  - The winner is the first i with REQ_VALID[i]=1, scanning PTR, PTR+1, … modulo NREQ.
  - PTR advances to (winner+1) mod NREQ on acceptance only.
  - For NREQ not a power of two, the wrap is explicit (NREQ-1 → 0).
- In IDLE, REQ_READY[winner]=1 when any valid is present. All other REQ_READY bits are 0. All REQ_READY bits are 0 outside IDLE.
- Acceptance is a cycle with REQ_VALID[i] & REQ_READY[i]. On the next edge:
  - REG_D ← REQ_DATA[i].
  - GRANT_ID ← i.
  - REG_WE ← 1.
  - State moves to WRITE.
- WRITE lasts one cycle. On the next edge REG_WE ← 0, then:
  - SETTLE=0: state goes to IDLE.
  - Otherwise: state goes to SETTLE with counter ← SETTLE-1.
- SETTLE decrements each cycle and goes to IDLE on the edge where the counter equals 0.
- REG_D and GRANT_ID hold their values until the next acceptance. REG_D must stay stable throughout WRITE and SETTLE.
- Requesters must hold REQ_VALID and REQ_DATA stable until accepted. A requester may drop REQ_VALID before acceptance; it is then simply not chosen.
- Changes to REQ_VALID or REQ_DATA while in WRITE or SETTLE have no effect.
- If no request is valid in IDLE, the FSM stays in IDLE, the outputs are unchanged and PTR is unchanged.

## Timing
- Reset values (while ARST=0, applied immediately):
  - State IDLE, PTR 0, counter 0.
  - REG_WE 0, REG_D 0, GRANT_ID 0, BUSY 0.
  - REQ_READY is all zeros while reset is asserted.
- Latency: acceptance in cycle t gives REG_WE=1 in cycle t+1.
  - BUSY is high over cycles t+1 … t+1+SETTLE.
  - The next acceptance is possible no earlier than cycle t+2+SETTLE.
- Throughput: one write per SETTLE+2 cycles when requests are continuously pending.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…. Starvation is bounded to NREQ-1 intervening grants.
- Reset asserted mid-WRITE or mid-SETTLE:
  - REG_WE drops immediately and the strobe is truncated.
  - The accepted request is considered consumed and is not re-served.
- Reset release has no combinational effect. The first acceptance can occur in the first cycle after ARST rises.

## Test plan
- Reset: hold ARST=0 with REQ_VALID=all ones → REQ_READY=0, REG_WE=0, REG_D=0, BUSY=0, GRANT_ID=0.
- Single write, SETTLE=2: REQ_VALID[2]=1, data 8'hA5, in IDLE → REQ_READY=4'b0100 that cycle.
  - Next cycle: REG_WE=1, REG_D=A5, GRANT_ID=2.
  - BUSY high for 3 cycles.
  - PTR=3 afterwards.
- Round-robin: all four requesters valid continuously with data 8'h10..8'h13 → GRANT_ID sequence 0,1,2,3,0.
  - REG_WE pulses spaced exactly 4 cycles apart.
  - REG_D follows 10,11,12,13,10.
- Wrap and skip, after PTR=3: only requesters 1 and 3 valid → grants 3 then 1.
  - NREQ=3 build: PTR wraps 2 → 0.
- SETTLE=0: two requesters continuously valid → REG_WE pulses every 2 cycles and BUSY high only during WRITE.
- Reset mid-SETTLE: assert ARST=0 one cycle after REG_WE, then release → BUSY=0 and REG_D=0 immediately.
  - The previously granted requester is not re-granted unless it is still valid and wins by the pointer starting at 0.
